// File: rtl/axis_result_packer.sv
// Serialises wide PE result words LSB-first into BUS_WIDTH AXI-Stream beats,
// with a one-entry pending buffer so back-to-back results stream without bubbles.
module axis_result_packer #(
    parameter int KERNEL_SIZE  = 3,
    parameter int DATA_WIDTH   = 8,
    parameter int WEIGHT_WIDTH = 8,
    parameter int BUS_WIDTH    = 32,
    parameter int FRAME_LEN    = 16,
    localparam int IN_WIDTH    = (DATA_WIDTH + WEIGHT_WIDTH + KERNEL_SIZE) * KERNEL_SIZE
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [IN_WIDTH-1:0]  s_axis_tdata,
    input  logic                 s_axis_tvalid,
    output logic                 s_axis_tready,
    output logic [BUS_WIDTH-1:0] m_axis_tdata,
    output logic                 m_axis_tvalid,
    input  logic                 m_axis_tready,
    output logic                 m_axis_tlast,
    output logic                 busy
);
    localparam int BEATS = (IN_WIDTH + BUS_WIDTH - 1) / BUS_WIDTH;
    localparam int PAD_W = BEATS * BUS_WIDTH;
    localparam int BCW   = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int RCW   = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [BCW-1:0] LAST_BEAT = BCW'(BEATS - 1);
    localparam logic [RCW-1:0] LAST_RES  = RCW'(FRAME_LEN - 1);

    logic [PAD_W-1:0]    r_active;
    logic                r_active_valid;
    logic [BCW-1:0]      r_beat_cnt;
    logic [RCW-1:0]      r_res_cnt;
    logic [IN_WIDTH-1:0] r_pend;
    logic                r_pend_valid;

    logic [PAD_W-1:0]    w_in_pad;
    logic [PAD_W-1:0]    w_pend_pad;
    logic [PAD_W-1:0]    w_shifted;
    logic                w_s_fire;
    logic                w_m_fire;
    logic                w_last_beat;

    assign w_in_pad    = PAD_W'(s_axis_tdata);
    assign w_pend_pad  = PAD_W'(r_pend);
    assign w_s_fire    = s_axis_tvalid && s_axis_tready;
    assign w_m_fire    = r_active_valid && m_axis_tready;
    assign w_last_beat = (r_beat_cnt == LAST_BEAT);

    // Single-beat configurations never shift, so the upper slice does not exist there.
    generate
        if (BEATS > 1) begin : g_multi_beat
            assign w_shifted = {{BUS_WIDTH{1'b0}}, r_active[PAD_W-1:BUS_WIDTH]};
        end else begin : g_single_beat
            assign w_shifted = '0;
        end
    endgenerate

    assign s_axis_tready = !r_pend_valid;
    assign m_axis_tvalid = r_active_valid;
    assign m_axis_tdata  = r_active[BUS_WIDTH-1:0];
    assign m_axis_tlast  = r_active_valid && w_last_beat && (r_res_cnt == LAST_RES);
    assign busy          = r_active_valid || r_pend_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_active       <= '0;
            r_active_valid <= 1'b0;
            r_beat_cnt     <= '0;
            r_res_cnt      <= '0;
            r_pend         <= '0;
            r_pend_valid   <= 1'b0;
        end else if (!r_active_valid) begin
            if (w_s_fire) begin
                r_active       <= w_in_pad;
                r_active_valid <= 1'b1;
                r_beat_cnt     <= '0;
            end
        end else if (w_m_fire && !w_last_beat) begin
            r_active   <= w_shifted;
            r_beat_cnt <= r_beat_cnt + BCW'(1);
            if (w_s_fire) begin
                r_pend       <= s_axis_tdata;
                r_pend_valid <= 1'b1;
            end
        end else if (w_m_fire) begin
            r_res_cnt  <= (r_res_cnt == LAST_RES) ? '0 : r_res_cnt + RCW'(1);
            r_beat_cnt <= '0;
            // Pending result takes precedence; s_fire cannot coincide because tready is low then.
            if (r_pend_valid) begin
                r_active     <= w_pend_pad;
                r_pend_valid <= 1'b0;
            end else if (w_s_fire) begin
                r_active <= w_in_pad;
            end else begin
                r_active_valid <= 1'b0;
            end
        end else if (w_s_fire) begin
            r_pend       <= s_axis_tdata;
            r_pend_valid <= 1'b1;
        end
    end
endmodule
